// File: rtl/v_pkg.sv
// Shared VLSU definitions: load-op codes, SEW/LMUL decode, load-unit states.
// DATAMEM_BITS falls back to an 11-bit word address when not set by the build.
`ifndef DATAMEM_BITS
`define DATAMEM_BITS 11
`endif

package v_pkg;

  localparam logic [3:0] VLSU_VLE8   = 4'h0;
  localparam logic [3:0] VLSU_VLE16  = 4'h1;
  localparam logic [3:0] VLSU_VLE32  = 4'h2;
  localparam logic [3:0] VLSU_VLSE8  = 4'h4;
  localparam logic [3:0] VLSU_VLSE16 = 4'h5;
  localparam logic [3:0] VLSU_VLSE32 = 4'h6;

  typedef enum logic [1:0] {
    LU_IDLE,
    LU_RUN,
    LU_DRAIN,
    LU_DONE
  } lu_state_t;

  function automatic logic [5:0] sew_bits(input logic [2:0] vsew);
    case (vsew)
      3'b000:  return 6'd8;
      3'b001:  return 6'd16;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [2:0] nreg(input logic [2:0] lmul);
    case (lmul)
      3'b001:  return 3'd2;
      3'b010:  return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Unknown op codes fall through to unit-stride.
  function automatic logic is_strided(input logic [3:0] op);
    return (op == VLSU_VLSE8) || (op == VLSU_VLSE16) ||
           (op == VLSU_VLSE32);
  endfunction

endpackage

// File: rtl/v_ld_addrgen.sv
// Per-beat bank address generator for the vector load unit.
// Lane I of beat k addresses element 4k+I; arithmetic wraps mod 2^ADDR_W.
module v_ld_addrgen #(
  parameter int ADDR_W = `DATAMEM_BITS
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [4:0]        stride,
  input  logic              strided,
  input  logic [3:0]        beat,
  output logic [ADDR_W-1:0] addr0,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr3
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] e0;
  logic [ADDR_W-1:0] e1;
  logic [ADDR_W-1:0] e2;
  logic [ADDR_W-1:0] e3;

  assign step = strided ? ADDR_W'(stride) : ADDR_W'(1);

  assign e0 = ADDR_W'({beat, 2'd0});
  assign e1 = ADDR_W'({beat, 2'd1});
  assign e2 = ADDR_W'({beat, 2'd2});
  assign e3 = ADDR_W'({beat, 2'd3});

  assign addr0 = base + e0 * step;
  assign addr1 = base + e1 * step;
  assign addr2 = base + e2 * step;
  assign addr3 = base + e3 * step;

endmodule

// File: rtl/v_loadunit.sv
// Vector load data unit: issues 4-bank word reads and packs the returned
// elements into a 512-bit register-group image for the VRF.
module v_loadunit
  import v_pkg::*;
#(
  parameter int VLEN   = 128,
  parameter int ADDR_W = `DATAMEM_BITS,
  parameter int NBANK  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        load_op,
  input  logic [2:0]        lmul,
  input  logic [2:0]        vsew,
  input  logic [4:0]        stride,
  input  logic [ADDR_W-1:0] address,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] rd_addr3,
  input  logic [31:0]       rd_data0,
  input  logic [31:0]       rd_data1,
  input  logic [31:0]       rd_data2,
  input  logic [31:0]       rd_data3,
  output logic              busy,
  output logic              done,
  output logic [511:0]      data_out
);

  lu_state_t         state;
  lu_state_t         state_nx;
  logic [ADDR_W-1:0] base_q;
  logic [4:0]        stride_q;
  logic              strided_q;
  logic [5:0]        sew_q;
  logic [4:0]        nbeat_q;
  logic [4:0]        k_q;
  logic [511:0]      asm_q;
  logic [511:0]      asm_nx;
  logic              cap;
  logic [3:0]        cap_beat;
  logic [31:0]       rdw [4];
  logic [ADDR_W-1:0] ga0;
  logic [ADDR_W-1:0] ga1;
  logic [ADDR_W-1:0] ga2;
  logic [ADDR_W-1:0] ga3;

  v_ld_addrgen #(.ADDR_W(ADDR_W)) u_agen (
    .base    (base_q),
    .stride  (stride_q),
    .strided (strided_q),
    .beat    (k_q[3:0]),
    .addr0   (ga0),
    .addr1   (ga1),
    .addr2   (ga2),
    .addr3   (ga3)
  );

  assign rd_en    = (state == LU_RUN);
  assign busy     = (state == LU_RUN) || (state == LU_DRAIN);
  assign done     = (state == LU_DONE);
  assign rd_addr0 = rd_en ? ga0 : '0;
  assign rd_addr1 = rd_en ? ga1 : '0;
  assign rd_addr2 = rd_en ? ga2 : '0;
  assign rd_addr3 = rd_en ? ga3 : '0;

  assign rdw = '{rd_data0, rd_data1, rd_data2, rd_data3};

  // Read data lags issue by one cycle, so capture always trails by a beat.
  assign cap      = ((state == LU_RUN) && (k_q != 5'd0)) ||
                    (state == LU_DRAIN);
  assign cap_beat = 4'(k_q - 5'd1);

  always_comb begin
    state_nx = state;
    case (state)
      LU_IDLE:  if (start) state_nx = LU_RUN;
      LU_RUN:   if (k_q == nbeat_q - 5'd1) state_nx = LU_DRAIN;
      LU_DRAIN: state_nx = LU_DONE;
      LU_DONE:  state_nx = LU_IDLE;
      default:  state_nx = LU_IDLE;
    endcase
  end

  always_comb begin
    asm_nx = asm_q;
    if (cap) begin
      for (int i = 0; i < NBANK; i++) begin
        unique case (1'b1)
          (sew_q == 6'd8):
            asm_nx[(int'(cap_beat) * 4 + i) * 8 +: 8] = rdw[i][7:0];
          (sew_q == 6'd16):
            asm_nx[(int'(cap_beat) * 4 + i) * 16 +: 16] = rdw[i][15:0];
          default:
            asm_nx[(int'(cap_beat) * 4 + i) * 32 +: 32] = rdw[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LU_IDLE;
      base_q    <= '0;
      stride_q  <= '0;
      strided_q <= 1'b0;
      sew_q     <= '0;
      nbeat_q   <= '0;
      k_q       <= '0;
      asm_q     <= '0;
      data_out  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        LU_IDLE: begin
          if (start) begin
            base_q    <= address;
            stride_q  <= stride;
            strided_q <= is_strided(load_op);
            sew_q     <= sew_bits(vsew);
            nbeat_q   <= 5'((int'(nreg(lmul)) * VLEN) /
                            (NBANK * int'(sew_bits(vsew))));
            k_q       <= '0;
            asm_q     <= '0;
          end
        end
        LU_RUN: begin
          k_q   <= k_q + 5'd1;
          asm_q <= asm_nx;
        end
        LU_DRAIN: begin
          asm_q    <= asm_nx;
          data_out <= asm_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_v_loadunit.sv
// Self-checking bench for v_loadunit: directed cases plus random loads
// against a flat element-list model of the load.
module tb_v_loadunit;
  import v_pkg::*;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    load_op = '0;
  logic [2:0]    lmul = '0;
  logic [2:0]    vsew = '0;
  logic [4:0]    stride = '0;
  logic [AW-1:0] address = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [31:0]   rd_data0 = '0, rd_data1 = '0;
  logic [31:0]   rd_data2 = '0, rd_data3 = '0;
  logic          busy, done;
  logic [511:0]  data_out;

  logic [31:0]   mem [0:2047];
  int total = 0;
  int bad = 0;

  v_loadunit #(.VLEN(128), .ADDR_W(AW), .NBANK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .load_op(load_op),
    .lmul(lmul), .vsew(vsew), .stride(stride), .address(address),
    .rd_en(rd_en),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_data0(rd_data0), .rd_data1(rd_data1),
    .rd_data2(rd_data2), .rd_data3(rd_data3),
    .busy(busy), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data0 <= mem[rd_addr0];
      rd_data1 <= mem[rd_addr1];
      rd_data2 <= mem[rd_addr2];
      rd_data3 <= mem[rd_addr3];
    end
  end

  task automatic chk(input logic [511:0] obs, input logic [511:0] exp,
                     input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_sew(input logic [2:0] vs);
    return (vs == 3'd0) ? 8 : (vs == 3'd1) ? 16 : 32;
  endfunction

  function automatic int m_nreg(input logic [2:0] lm);
    return (lm == 3'd1) ? 2 : (lm == 3'd2) ? 4 : 1;
  endfunction

  function automatic logic [AW-1:0] m_addr(input logic [3:0] op,
      input logic [4:0] st, input logic [AW-1:0] ad, input int j);
    int step;
    step = (op == VLSU_VLSE8 || op == VLSU_VLSE16 ||
            op == VLSU_VLSE32) ? int'(st) : 1;
    return AW'(int'(ad) + j * step);
  endfunction

  logic [511:0] last_exp;

  task automatic run_op(input logic [3:0] op, input logic [2:0] lm,
      input logic [2:0] vs, input logic [4:0] st,
      input logic [AW-1:0] ad, input int restart_c, input int rst_c,
      input string tag);
    int sew, e, nb;
    logic [511:0] ex;
    logic [31:0] w;
    logic [AW-1:0] ea [4];
    sew = m_sew(vs);
    e = m_nreg(lm) * 128 / sew;
    nb = e / 4;
    ex = '0;
    for (int j = 0; j < e; j++) begin
      w = mem[m_addr(op, st, ad, j)];
      for (int b = 0; b < sew; b++) ex[j * sew + b] = w[b];
    end
    @(negedge clk);
    start = 1'b1; load_op = op; lmul = lm; vsew = vs;
    stride = st; address = ad;
    @(negedge clk);
    for (int c = 1; c <= nb + 2; c++) begin
      start = 1'b0;
      chk(512'(busy), 512'(c <= nb + 1), {tag, " busy"});
      chk(512'(done), 512'(c == nb + 2), {tag, " done"});
      chk(512'(rd_en), 512'(c <= nb), {tag, " rd_en"});
      if (c <= nb) begin
        for (int i = 0; i < 4; i++)
          ea[i] = m_addr(op, st, ad, 4 * (c - 1) + i);
        chk(512'(rd_addr0), 512'(ea[0]), {tag, " addr0"});
        chk(512'(rd_addr1), 512'(ea[1]), {tag, " addr1"});
        chk(512'(rd_addr2), 512'(ea[2]), {tag, " addr2"});
        chk(512'(rd_addr3), 512'(ea[3]), {tag, " addr3"});
      end
      if (c <= nb + 1)
        chk(data_out, last_exp, {tag, " data_out held"});
      if (c == nb + 2)
        chk(data_out, ex, {tag, " data_out"});
      if (c == rst_c) begin
        rst = 1'b1;
        #1;
        chk(512'(rd_en), 512'(0), {tag, " rst rd_en"});
        chk(512'({rd_addr0, rd_addr1, rd_addr2, rd_addr3}), 512'(0),
            {tag, " rst addr"});
        chk(512'(busy), 512'(0), {tag, " rst busy"});
        chk(512'(done), 512'(0), {tag, " rst done"});
        chk(data_out, 512'(0), {tag, " rst data_out"});
        last_exp = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk(512'(busy), 512'(0), {tag, " post-rst busy"});
        return;
      end
      if (c == restart_c || c == nb + 2) begin
        start = 1'b1; load_op = VLSU_VLE8; lmul = 3'd0; vsew = 3'd0;
        stride = 5'd7; address = AW'(ad + 11'h155);
      end
      @(negedge clk);
    end
    start = 1'b0;
    last_exp = ex;
    chk(512'(busy), 512'(0), {tag, " start-in-done busy"});
    chk(512'(done), 512'(0), {tag, " done pulse"});
    @(negedge clk);
    chk(data_out, ex, {tag, " data_out kept"});
  endtask

  initial begin
    logic [3:0] rop;
    logic [2:0] rvs;
    logic [127:0] k1;
    last_exp = '0;
    for (int a = 0; a < 2048; a++) mem[a] = 32'(a);
    #1;
    chk(512'({rd_en, busy, done}), 512'(0), "reset ctl");
    chk(data_out, 512'(0), "reset data_out");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(VLSU_VLE32, 3'd0, 3'd2, 5'd0, 11'h010, 0, 0, "vle32");
    k1 = 128'h00000013_00000012_00000011_00000010;
    chk(data_out[127:0], 512'(k1), "vle32 const");

    for (int a = 0; a < 2048; a++) mem[a] = 32'hFFFFFF00 | 32'(a[7:0]);
    run_op(VLSU_VLE8, 3'd2, 3'd0, 5'd0, 11'h000, 0, 0, "vle8 m4");

    for (int a = 0; a < 2048; a++) mem[a] = $urandom;
    run_op(VLSU_VLSE16, 3'd1, 3'd1, 5'd3, 11'h7F0, 0, 0, "vlse16 wrap");
    chk(data_out[511:256], 512'(0), "vlse16 upper");
    run_op(VLSU_VLSE32, 3'd0, 3'd2, 5'd0, 11'h123, 0, 0, "vlse32 s0");
    chk(512'(data_out[31:0]), 512'(mem[11'h123]), "s0 word");
    run_op(VLSU_VLE16, 3'd2, 3'd1, 5'd0, 11'h200, 2, 0, "restart");
    run_op(VLSU_VLE8, 3'd2, 3'd0, 5'd0, 11'h300, 0, 3, "rst mid");
    run_op(VLSU_VLE32, 3'd0, 3'd2, 5'd0, 11'h040, 0, 0, "after rst");
    run_op(4'hF, 3'd0, 3'd2, 5'd9, 11'h050, 0, 0, "bad op");

    for (int t = 0; t < 20; t++) begin
      rop = 4'($urandom_range(0, 6));
      if (rop == 4'h3) rop = 4'hB;
      rvs = (rop == VLSU_VLE8 || rop == VLSU_VLSE8) ? 3'd0 :
            (rop == VLSU_VLE16 || rop == VLSU_VLSE16) ? 3'd1 : 3'd2;
      if (rvs == 3'd2 && ($urandom_range(0, 1) == 1)) rvs = 3'd5;
      run_op(rop, 3'($urandom_range(0, 7)), rvs, 5'($urandom),
             11'($urandom), 0, 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
